// File: rtl/camera_pattern_pkg.sv
// Shared encodings for the parallel-camera pattern source: FSM states and pattern modes.
`timescale 1ns/1ps
package camera_pattern_pkg;

   // Width of the row/column indices handed to the pattern generator
   localparam int IDX_W = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_VSYNC  = 3'd1;
   localparam logic [2:0] ST_PRE    = 3'd2;
   localparam logic [2:0] ST_LINE   = 3'd3;
   localparam logic [2:0] ST_HBLANK = 3'd4;
   localparam logic [2:0] ST_POST   = 3'd5;

   localparam logic [2:0] MODE_ROW     = 3'd0;
   localparam logic [2:0] MODE_COL     = 3'd1;
   localparam logic [2:0] MODE_CHECKER = 3'd2;
   localparam logic [2:0] MODE_COUNT   = 3'd3;
   localparam logic [2:0] MODE_CONST   = 3'd4;

endpackage

// File: rtl/camera_pattern_src_if.sv
// Parallel-camera video bus: pixel data qualified by href, framed by vsync.
`timescale 1ns/1ps
interface camera_pattern_src_if #(
   parameter int PIX_W = 10
);

   logic [PIX_W-1:0] pixel;
   logic             vsync;
   logic             href;

   modport master (output pixel, output vsync, output href);
   modport slave  (input  pixel, input  vsync, input  href);

endinterface

// File: rtl/camera_pattern_gen.sv
// Combinational test-pattern generator; the parent registers its output.
`timescale 1ns/1ps
module camera_pattern_gen
   import camera_pattern_pkg::*;
#(
   parameter int PIX_W = 10
) (
   input  logic [IDX_W-1:0] row,
   input  logic [IDX_W-1:0] col,
   input  logic [PIX_W-1:0] pix_cnt,
   input  logic [2:0]       mode,
   input  logic [PIX_W-1:0] const_val,
   output logic [PIX_W-1:0] pix_nxt
);

   always_comb begin
      pix_nxt = '0;
      case (mode)
         MODE_ROW:     pix_nxt = PIX_W'(row);
         MODE_COL:     pix_nxt = PIX_W'(col);
         MODE_CHECKER: pix_nxt = (row[3] ^ col[3]) ? '1 : '0;
         MODE_COUNT:   pix_nxt = pix_cnt;
         MODE_CONST:   pix_nxt = const_val;
         default:      pix_nxt = '0;
      endcase
   end

endmodule

// File: rtl/camera_pattern_src.sv
// Parametrised camera stimulus source: vsync/href/pixel timing with selectable test patterns.
`timescale 1ns/1ps
module camera_pattern_src
   import camera_pattern_pkg::*;
#(
   parameter int PIX_W           = 10,
   parameter int COLS            = 640,
   parameter int ROWS            = 480,
   parameter int VSYNC_CLKS      = 1000,
   parameter int PRE_FRAME_CLKS  = 27193,
   parameter int H_BLANK_CLKS    = 322,
   parameter int POST_FRAME_CLKS = 30000,
   parameter int CTR_W           = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 start,
   input  logic [2:0]           mode,
   input  logic [PIX_W-1:0]     const_val,
   camera_pattern_src_if.master vid,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          frame_cnt
);

   logic [2:0]       state, state_nxt;
   logic [CTR_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] row, row_nxt;
   logic [PIX_W-1:0] pix_cnt;
   logic [2:0]       mode_q;
   logic [PIX_W-1:0] const_q;
   logic [PIX_W-1:0] pix_nxt;
   logic             frame_start, frame_end;

   // cnt times every phase; while in LINE it doubles as the column index
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CTR_W'(1);
      row_nxt     = row;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (enable | start) begin
               state_nxt   = ST_VSYNC;
               frame_start = 1'b1;
            end
         end
         ST_VSYNC: begin
            if (cnt == CTR_W'(VSYNC_CLKS - 1)) begin
               state_nxt = ST_PRE;
               cnt_nxt   = '0;
            end
         end
         ST_PRE: begin
            if (cnt == CTR_W'(PRE_FRAME_CLKS - 1)) begin
               state_nxt = ST_LINE;
               cnt_nxt   = '0;
               row_nxt   = '0;
            end
         end
         ST_LINE: begin
            if (cnt == CTR_W'(COLS - 1)) begin
               cnt_nxt   = '0;
               state_nxt = (row == IDX_W'(ROWS - 1)) ? ST_POST : ST_HBLANK;
            end
         end
         ST_HBLANK: begin
            if (cnt == CTR_W'(H_BLANK_CLKS - 1)) begin
               state_nxt = ST_LINE;
               cnt_nxt   = '0;
               row_nxt   = row + IDX_W'(1);
            end
         end
         ST_POST: begin
            if (cnt == CTR_W'(POST_FRAME_CLKS - 1)) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               frame_end = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   camera_pattern_gen #(
      .PIX_W (PIX_W)
   ) u_gen (
      .row       (row_nxt),
      .col       (IDX_W'(cnt_nxt)),
      .pix_cnt   (pix_cnt),
      .mode      (mode_q),
      .const_val (const_q),
      .pix_nxt   (pix_nxt)
   );

   // Output register stage: outputs are decoded from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         row        <= '0;
         pix_cnt    <= '0;
         mode_q     <= '0;
         const_q    <= '0;
         vid.pixel  <= '0;
         vid.vsync  <= 1'b0;
         vid.href   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         row   <= row_nxt;
         if (frame_start) begin
            mode_q  <= mode;
            const_q <= const_val;
         end
         if (frame_start)
            pix_cnt <= '0;
         else if (state_nxt == ST_LINE)
            pix_cnt <= pix_cnt + PIX_W'(1);
         vid.vsync  <= (state_nxt == ST_VSYNC);
         vid.href   <= (state_nxt == ST_LINE);
         vid.pixel  <= (state_nxt == ST_LINE) ? pix_nxt : '0;
         busy       <= (state_nxt != ST_IDLE);
         frame_done <= frame_end;
         if (frame_end)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_camera_pattern_src.sv
// Bench for camera_pattern_src: two geometries checked cycle by cycle against a frame-level model.
`timescale 1ns/1ps
module tb_camera_pattern_src;

   localparam int PW = 10, V = 2, PRE = 3, H = 2, POST = 4;
   localparam int C1 = 4, R1 = 3, C2 = 16, R2 = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          en1 = 1'b0, st1 = 1'b0, en2 = 1'b0, st2 = 1'b0;
   logic [2:0]    md1 = '0, md2 = '0;
   logic [PW-1:0] cv1 = '0, cv2 = '0;
   logic          busy1, fd1, busy2, fd2;
   logic [15:0]   fc1, fc2;

   camera_pattern_src_if #(.PIX_W(PW)) vid1 ();
   camera_pattern_src_if #(.PIX_W(PW)) vid2 ();

   camera_pattern_src #(
      .PIX_W(PW), .COLS(C1), .ROWS(R1), .VSYNC_CLKS(V), .PRE_FRAME_CLKS(PRE),
      .H_BLANK_CLKS(H), .POST_FRAME_CLKS(POST), .CTR_W(16)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(en1), .start(st1), .mode(md1), .const_val(cv1),
      .vid(vid1), .busy(busy1), .frame_done(fd1), .frame_cnt(fc1)
   );

   camera_pattern_src #(
      .PIX_W(PW), .COLS(C2), .ROWS(R2), .VSYNC_CLKS(V), .PRE_FRAME_CLKS(PRE),
      .H_BLANK_CLKS(H), .POST_FRAME_CLKS(POST), .CTR_W(16)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .start(st2), .mode(md2), .const_val(cv2),
      .vid(vid2), .busy(busy2), .frame_done(fd2), .frame_cnt(fc2)
   );

   logic [13:0] vec1, vec2;
   assign vec1 = {vid1.vsync, vid1.href, busy1, fd1, vid1.pixel};
   assign vec2 = {vid2.vsync, vid2.href, busy2, fd2, vid2.pixel};

   int total = 0, bad = 0, frames1 = 0;

   function automatic int period(input int c, input int r);
      return 1 + V + PRE + r * c + (r - 1) * H + POST;
   endfunction

   // Expected {vsync, href, busy, frame_done, pixel} k cycles after the edge that starts a frame
   function automatic logic [13:0] exp_vec(input int k, input int md, input int cv,
                                            input int c, input int r);
      int       p, off, row, col;
      bit       vs, hr, bs, fd;
      bit [9:0] pix;
      p   = period(c, r);
      off = k - (1 + V + PRE);
      row = 0;
      col = 0;
      hr  = 1'b0;
      pix = '0;
      if (off >= 0) begin
         row = off / (c + H);
         col = off % (c + H);
         hr  = (row < r) && (col < c);
      end
      if (hr) begin
         case (md)
            0:       pix = 10'(row);
            1:       pix = 10'(col);
            2:       pix = (((row >> 3) ^ (col >> 3)) & 1) != 0 ? 10'h3FF : 10'h000;
            3:       pix = 10'((row * c + col) % 1024);
            4:       pix = 10'(cv);
            default: pix = '0;
         endcase
      end
      vs = (k >= 1) && (k <= V);
      bs = (k >= 1) && (k < p);
      fd = (k == p);
      return {vs, hr, bs, fd, pix};
   endfunction

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({vec1, vec2} !== 28'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {vec1, vec2});
      end
      total++;
      if (fc1 !== 16'd0) begin
         bad++;
         $display("FAIL reset_frame_cnt got=%0d want=0", fc1);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_row();
      logic [13:0] e;
      int p = period(C1, R1);
      md1 = 3'd0;
      st1 = 1'b1;
      for (int k = 1; k <= p; k++) begin
         @(negedge clk);
         st1 = 1'b0;
         e = exp_vec(k, 0, 0, C1, R1);
         total++;
         if (vec1 !== e) begin
            bad++;
            $display("FAIL single_row k=%0d got=%h want=%h", k, vec1, e);
         end
      end
      frames1++;
      total++;
      if (fc1 !== 16'(frames1)) begin
         bad++;
         $display("FAIL single_row_cnt got=%0d want=%0d", fc1, frames1);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         total++;
         if (vec1 !== 14'h0) begin
            bad++;
            $display("FAIL single_row_idle k=%0d got=%h want=0", k, vec1);
         end
      end
   endtask

   task automatic test_patterns();
      logic [13:0] e;
      int p = period(C1, R1);
      int lm, lc, chg;
      for (int f = 0; f < 4; f++) begin
         lm  = (f == 0) ? 1 : (f == 1) ? 4 : int'($urandom_range(0, 7));
         lc  = (f == 1) ? 'h2A5 : int'($urandom_range(0, 1023));
         md1 = 3'(lm);
         cv1 = 10'(lc);
         chg = int'($urandom_range(2, p - 2));
         st1 = 1'b1;
         for (int k = 1; k <= p; k++) begin
            @(negedge clk);
            st1 = 1'b0;
            if (k == chg) begin
               md1 = 3'($urandom_range(0, 7));
               cv1 = 10'($urandom_range(0, 1023));
            end
            e = exp_vec(k, lm, lc, C1, R1);
            total++;
            if (vec1 !== e) begin
               bad++;
               $display("FAIL pattern f=%0d mode=%0d k=%0d got=%h want=%h", f, lm, k, vec1, e);
            end
         end
         frames1++;
         total++;
         if (fc1 !== 16'(frames1)) begin
            bad++;
            $display("FAIL pattern_cnt got=%0d want=%0d", fc1, frames1);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_free_run();
      logic [13:0] e;
      int p = period(C1, R1);
      int lm, lc, chg, drop;
      md1 = 3'd3;
      en1 = 1'b1;
      for (int f = 0; f < 3; f++) begin
         lm   = int'(md1);
         lc   = int'(cv1);
         chg  = int'($urandom_range(2, p - 2));
         drop = int'($urandom_range(1, p - 1));
         for (int k = 1; k <= p; k++) begin
            @(negedge clk);
            if (f == 1 && k == chg) begin
               md1 = 3'($urandom_range(0, 7));
               cv1 = 10'($urandom_range(0, 1023));
            end
            if (f == 2 && k == drop) en1 = 1'b0;
            if (f == 2 && (k % 5) == 3) st1 = 1'b1;
            else st1 = 1'b0;
            e = exp_vec(k, lm, lc, C1, R1);
            total++;
            if (vec1 !== e) begin
               bad++;
               $display("FAIL free_run f=%0d k=%0d got=%h want=%h", f, k, vec1, e);
            end
         end
         frames1++;
         total++;
         if (fc1 !== 16'(frames1)) begin
            bad++;
            $display("FAIL free_run_cnt got=%0d want=%0d", fc1, frames1);
         end
      end
      st1 = 1'b0;
      for (int k = 0; k < 2 * p; k++) begin
         @(negedge clk);
         total++;
         if (vec1 !== 14'h0) begin
            bad++;
            $display("FAIL free_run_stop k=%0d got=%h want=0", k, vec1);
         end
      end
   endtask

   task automatic test_checker();
      logic [13:0] e;
      logic [9:0]  pix2 [R2][C2];
      int p = period(C2, R2);
      int n = 0;
      md2 = 3'd2;
      st2 = 1'b1;
      for (int k = 1; k <= p; k++) begin
         @(negedge clk);
         st2 = 1'b0;
         if (vid2.href === 1'b1 && n < R2 * C2) begin
            pix2[n / C2][n % C2] = vid2.pixel;
            n++;
         end
         e = exp_vec(k, 2, 0, C2, R2);
         total++;
         if (vec2 !== e) begin
            bad++;
            $display("FAIL checker k=%0d got=%h want=%h", k, vec2, e);
         end
      end
      total++;
      if (n != R2 * C2) begin
         bad++;
         $display("FAIL checker_pixels got=%0d want=%0d", n, R2 * C2);
      end else begin
         total += 3;
         if (pix2[0][8] !== 10'h3FF) begin
            bad++;
            $display("FAIL checker_0_8 got=%h want=3ff", pix2[0][8]);
         end
         if (pix2[8][8] !== 10'h000) begin
            bad++;
            $display("FAIL checker_8_8 got=%h want=0", pix2[8][8]);
         end
         if (pix2[0][0] !== 10'h000) begin
            bad++;
            $display("FAIL checker_0_0 got=%h want=0", pix2[0][0]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      logic [13:0] e;
      int p = period(C1, R1);
      int lm;
      bit saw_done = 1'b0;
      md1 = 3'd0;
      st1 = 1'b1;
      // row 1 is on the line during k = 12..15
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         st1 = 1'b0;
      end
      e = exp_vec(13, 0, 0, C1, R1);
      total++;
      if (vec1 !== e) begin
         bad++;
         $display("FAIL pre_reset got=%h want=%h", vec1, e);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (vec1 !== 14'h0) begin
         bad++;
         $display("FAIL async_reset got=%h want=0", vec1);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (fd1 !== 1'b0) saw_done = 1'b1;
      end
      total++;
      if (saw_done || fc1 !== 16'd0) begin
         bad++;
         $display("FAIL reset_abort done=%0d cnt=%0d want done=0 cnt=0", saw_done, fc1);
      end
      rst_n  = 1'b1;
      frames1 = 0;
      @(negedge clk);
      lm  = int'($urandom_range(0, 4));
      md1 = 3'(lm);
      cv1 = 10'($urandom_range(0, 1023));
      st1 = 1'b1;
      for (int k = 1; k <= p; k++) begin
         @(negedge clk);
         st1 = 1'b0;
         e = exp_vec(k, lm, int'(cv1), C1, R1);
         total++;
         if (vec1 !== e) begin
            bad++;
            $display("FAIL after_reset k=%0d got=%h want=%h", k, vec1, e);
         end
      end
      frames1++;
      total++;
      if (fc1 !== 16'(frames1)) begin
         bad++;
         $display("FAIL after_reset_cnt got=%0d want=%0d", fc1, frames1);
      end
   endtask

   initial begin
      test_reset();
      test_single_row();
      test_patterns();
      test_free_run();
      test_checker();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/camera_pattern_src.md
Name: camera_pattern_src

Overview:
Parametrised parallel-camera stimulus source, the successor to the fixed 12x12 camera mock. It emits vsync/href/pixel timing with configurable geometry, blanking and pixel width. It offers selectable test patterns, single-shot or free-running frames, a frame counter and a frame-done strobe. It drives capture/DMA front-ends in simulation and on-board loopback.

Parameters:
PIX_W, 10, pixel data width (1..16)
COLS, 640, pixels per line (href-high cycles per line), >=1
ROWS, 480, lines per frame, >=1
VSYNC_CLKS, 1000, vsync high cycles, >=1
PRE_FRAME_CLKS, 27193, cycles from vsync fall to first href rise, >=1
H_BLANK_CLKS, 322, href-low cycles between consecutive lines, >=1
POST_FRAME_CLKS, 30000, cycles after last line before frame end, >=1
CTR_W, 16, width of shared delay counter; must hold max(all delays, COLS)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  free-running mode: start a new frame whenever idle
start  in  1  single-cycle request for one frame; ignored while busy
mode  in  3  pattern select, sampled at frame start
const_val  in  PIX_W  pixel value for constant mode, sampled at frame start
pixel  out  PIX_W  pixel data, valid only while href=1
vsync  out  1  frame sync, active high
href  out  1  line valid, active high
busy  out  1  high from frame start to frame end
frame_done  out  1  one-cycle pulse at frame end
frame_cnt  out  16  completed-frame count, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): state=IDLE. pixel=0, vsync=0, href=0, busy=0, frame_done=0, frame_cnt=0. Counters and latched mode are cleared. Reset mid-frame aborts the frame immediately, with no frame_done.
- All outputs are registered. pixel is 0 whenever href=0; it is never X or Z.
- FSM states: IDLE, VSYNC, PRE, LINE, HBLANK, POST.
- IDLE: if (enable | start) at cycle t, latch mode/const_val, go to VSYNC, busy=1 from t+1.
- VSYNC: vsync=1 for exactly VSYNC_CLKS cycles (t+1..t+VSYNC_CLKS), then PRE.
- PRE: exactly PRE_FRAME_CLKS cycles, vsync=0, then LINE with row=0, col=0.
- LINE: href=1 for exactly COLS cycles; col increments each cycle. After col=COLS-1: if row=ROWS-1 go to POST, else go to HBLANK.
- HBLANK: href=0 for exactly H_BLANK_CLKS cycles; row increments; col clears; then LINE.
- POST: exactly POST_FRAME_CLKS cycles. On exit go to IDLE; in that IDLE cycle frame_done=1, frame_cnt increments, busy=0.
- Frame period in free-run: 1 + VSYNC_CLKS + PRE_FRAME_CLKS + ROWS*COLS + (ROWS-1)*H_BLANK_CLKS + POST_FRAME_CLKS.
- enable deasserted mid-frame: the current frame completes normally, then the block stays IDLE.
- start while busy is dropped, not queued. start and enable high together start one frame.
- Pattern from latched mode, truncated to PIX_W LSBs:
  - 0: row index
  - 1: column index
  - 2: 8x8 checkerboard; all-ones if (row[3]^col[3]), else 0
  - 3: per-frame pixel counter; 0 at first pixel, +1 per href cycle, wraps at 2^PIX_W
  - 4: const_val
  - 5-7: 0
- Changing mode or const_val mid-frame has no effect until the next frame.

Decomposition:
- Package camera_pattern_pkg: FSM state encoding (3-bit), mode constants (MODE_ROW, MODE_COL, MODE_CHECKER, MODE_COUNT, MODE_CONST).
- Sub-module camera_pattern_gen: takes row, col, pixel counter, latched mode and const_val; outputs the next pixel value. It is combinational, and the parent registers its output.
- Timing FSM and counters stay in the top level.

Test Plan:
(Bench parameters: COLS=4, ROWS=3, VSYNC_CLKS=2, PRE_FRAME_CLKS=3, H_BLANK_CLKS=2, POST_FRAME_CLKS=4, PIX_W=10.)
- Single start pulse, mode=0 -> vsync high 2 cycles. href high 3 runs of 4 cycles, separated by 2 low cycles. pixel = 0,0,0,0 / 1,1,1,1 / 2,2,2,2. frame_done pulses once, 26 cycles after start. frame_cnt=1, busy low afterwards.
- enable held high, mode=3 -> consecutive vsync rises 26 cycles apart. Each frame shows pixels 0..11. frame_cnt increments by 1 per frame.
- mode=1, then mode=4 with const_val=0x2A5 -> first case: each line is 0,1,2,3. Second case: all 12 pixels are 0x2A5. Changing mode mid-frame leaves the current frame unchanged.
- Second bench, COLS=ROWS=16, mode=2 -> pixel(row=0,col=8)=0x3FF, pixel(8,8)=0, pixel(0,0)=0.
- start pulsed while busy; enable dropped mid-frame -> no extra frame is started. The current frame finishes and the block stays IDLE with busy=0.
- rst_n low during LINE of row 1 -> vsync, href, pixel and busy are 0 immediately (asynchronously), with no frame_done. frame_cnt=0. After release, a start produces a full correct frame.
